// File: rtl/multi_reg_sequencer_pkg.sv
// Shared definitions for the LM/SM multi-register sequencer.
// Holds the state encoding, the default address width and the IITB-RISC opcodes
// that decode uses to raise start/is_store.
package multi_reg_sequencer_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StIssue = ST_ISSUE,
        StDone  = ST_DONE
    } state_e;

    // IITB-RISC major opcodes (instruction bits [15:12])
    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    // Decode helpers: start = is_multi_reg_op(op), is_store = opcode_is_store(op)
    function automatic logic is_multi_reg_op(input logic [3:0] opcode);
        return (opcode == OPC_LM) || (opcode == OPC_SM);
    endfunction

    function automatic logic opcode_is_store(input logic [3:0] opcode);
        return opcode == OPC_SM;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder (purely combinational).
// Ports:
//   mask      in   NREG   bit vector to search
//   idx       out  IDX_W  index of the lowest set bit (0 when mask is empty)
//   any       out  1      mask has at least one bit set
//   clr_mask  out  NREG   mask with its lowest set bit cleared
module prio_enc_lsb #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [NREG-1:0]  mask,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [NREG-1:0]  clr_mask
);

    logic [NREG-1:0] onehot;

    // Scan high to low so the last hit (lowest index) wins.
    always_comb begin
        idx = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any      = |mask;
    assign onehot   = mask & (~mask + NREG'(1));
    assign clr_mask = mask & ~onehot;

endmodule

// File: rtl/multi_reg_sequencer.sv
// LM/SM micro-op sequencer. Latches a register mask and base address on start,
// then issues one index/address micro-op per set bit (R0 first) over a
// valid/ready handshake, holding fetch stalled until the list is exhausted and
// pulsing done once at the end. flush aborts at any point without done.
// Optional feature macro: MULTI_REG_BASE_WB_EN adds wb_valid/wb_addr, the
// post-increment base address (base + popcount(list)) reported alongside done.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start, is_store    sequence request and direction (sampled in IDLE)
//   reg_list, base_addr register mask and start address (sampled with start)
//   flush              abort to IDLE
//   uop_ready          downstream accepts current micro-op
//   uop_valid/idx/addr/is_store/last  micro-op presented downstream
//   busy, stall_fetch, done           sequence status
//   wb_valid, wb_addr  (macro only) base-register write-back
module multi_reg_sequencer
    import multi_reg_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned NREG   = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [NREG-1:0]   reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              uop_ready,
    output logic              uop_valid,
    output logic [IDX_W-1:0]  uop_idx,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_is_store,
    output logic              uop_last,
    output logic              busy,
    output logic              stall_fetch,
    output logic              done
`ifdef MULTI_REG_BASE_WB_EN
    ,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr
`endif
);

    state_e            state_q, state_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_store_q, is_store_d;

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;
    logic [NREG-1:0]   enc_clr;

    prio_enc_lsb #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .mask     (mask_q),
        .idx      (enc_idx),
        .any      (enc_any),
        .clr_mask (enc_clr)
    );

`ifdef MULTI_REG_BASE_WB_EN
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [ADDR_W-1:0] list_pop;

    always_comb begin
        list_pop = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            list_pop = list_pop + ADDR_W'(reg_list[i]);
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        is_store_d   = is_store_q;
`ifdef MULTI_REG_BASE_WB_EN
        wb_addr_d    = wb_addr_q;
`endif
        uop_valid    = 1'b0;
        uop_idx      = '0;
        uop_addr     = '0;
        uop_is_store = 1'b0;
        uop_last     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d     = reg_list;
                    addr_d     = base_addr;
                    is_store_d = is_store;
`ifdef MULTI_REG_BASE_WB_EN
                    wb_addr_d  = base_addr + list_pop;
`endif
                    state_d    = (reg_list == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                uop_valid    = enc_any;
                uop_idx      = enc_idx;
                uop_addr     = addr_q;
                uop_is_store = is_store_q;
                // Last when removing the lowest bit leaves nothing behind.
                uop_last     = enc_any && (enc_clr == '0);
                if (uop_valid && uop_ready) begin
                    mask_d = enc_clr;
                    addr_d = addr_q + ADDR_W'(1);
                    if (uop_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // flush overrides start and any accepting handshake this cycle.
        if (flush) begin
            state_d = StIdle;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            addr_q     <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            is_store_q <= is_store_d;
        end
    end

`ifdef MULTI_REG_BASE_WB_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_addr_q <= '0;
        end else begin
            wb_addr_q <= wb_addr_d;
        end
    end

    assign wb_valid = (state_q == StDone);
    assign wb_addr  = wb_addr_q;
`endif

    assign done        = (state_q == StDone);
    assign busy        = (state_q == StIssue) || (state_q == StDone);
    assign stall_fetch = busy || (start && (state_q == StIdle));

endmodule
